// File: rtl/pcie_vc_router_if.sv
// Handshake/data bundle for pcie_vc_router: write port, thresholds, output stream and status.
// Latency/backpressure are set by the router; the interface only adds wires.
interface pcie_vc_router_if #(
    parameter int DATA_W = 6,
    parameter int NUM_VC = 2,
    parameter int CNT_W  = 5
);
    logic              init;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic [CNT_W-1:0]  umbral_hi_in;
    logic [CNT_W-1:0]  umbral_lo_in;
    logic              out_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              in_pause;
    logic              idle_out;
    logic              active_out;
    logic              error_out;
    logic [NUM_VC-1:0] error_id;

    modport master (
        output init, in_valid, in_data, umbral_hi_in, umbral_lo_in, out_ready,
        input  out_valid, out_data, in_pause, idle_out, active_out, error_out, error_id
    );

    modport slave (
        input  init, in_valid, in_data, umbral_hi_in, umbral_lo_in, out_ready,
        output out_valid, out_data, in_pause, idle_out, active_out, error_out, error_id
    );
endinterface

// File: rtl/pcie_vc_router.sv
// Per-VC FIFO router; strict-priority arbiter, or round-robin when VC_RR_ARB_EN is defined.
// Latency: push at edge k can show on out_valid after edge k+1; out_ready=0 stalls the output, in_pause is hysteretic back-pressure.
module pcie_vc_router #(
    parameter int  DATA_W   = 6,
    parameter int  NUM_VC   = 2,
    parameter int  VC_DEPTH = 16,
    localparam int CNT_W    = $clog2(VC_DEPTH) + 1,
    localparam int VC_W     = $clog2(NUM_VC)
) (
    input  logic            clk,
    input  logic            reset,
    pcie_vc_router_if.slave vc_if
);
    localparam int               PTR_W   = $clog2(VC_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(VC_DEPTH);

    typedef enum logic [2:0] {
        ST_RESET,
        ST_INIT,
        ST_IDLE,
        ST_ACTIVE,
        ST_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q    [NUM_VC][VC_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_VC];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_VC];
    logic [CNT_W-1:0]  cnt_q    [NUM_VC];
    logic [CNT_W-1:0]  thr_hi_q, thr_hi_d;
    logic [CNT_W-1:0]  thr_lo_q, thr_lo_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              pause_q, pause_d;
    logic [NUM_VC-1:0] error_id_q, error_id_d;

    logic              run, any_ne, any_hi, all_lo;
    logic              load_raw, load, overflow, push;
    logic [VC_W-1:0]   push_vc, grant_vc;
    logic [NUM_VC-1:0] nonempty, full, push_vec, pop_vec;

    assign run     = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
    assign push_vc = vc_if.in_data[DATA_W-1 -: VC_W];

    always_comb begin
        nonempty = '0;
        full     = '0;
        any_hi   = 1'b0;
        all_lo   = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            nonempty[v] = (cnt_q[v] != '0);
            full[v]     = (cnt_q[v] == DEPTH_C);
            if (cnt_q[v] >= thr_hi_q) any_hi = 1'b1;
            if (cnt_q[v] > thr_lo_q)  all_lo = 1'b0;
        end
    end

    assign any_ne = |nonempty;

`ifdef VC_RR_ARB_EN
    // rr_ptr_q is where the next search begins: one past the last grant.
    logic [VC_W-1:0] rr_ptr_q;
    logic [VC_W-1:0] rr_idx;
    logic            rr_found;

    always_comb begin
        grant_vc = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            rr_idx = rr_ptr_q + VC_W'(i);
            if (!rr_found && nonempty[rr_idx]) begin
                grant_vc = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else if (load) begin
            rr_ptr_q <= grant_vc + VC_W'(1);
        end
    end
`else
    always_comb begin
        grant_vc = '0;
        for (int i = NUM_VC - 1; i >= 0; i--) begin
            if (nonempty[i]) grant_vc = VC_W'(i);
        end
    end
`endif

    // A pop of the target VC in the same cycle frees the slot the push needs.
    assign load_raw = run && (!out_valid_q || vc_if.out_ready) && any_ne;
    assign overflow = run && vc_if.in_valid && full[push_vc] &&
                      !(load_raw && (grant_vc == push_vc));
    assign load     = load_raw && !overflow;
    assign push     = run && vc_if.in_valid && !overflow;

    always_comb begin
        push_vec = '0;
        pop_vec  = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            push_vec[v] = push && (push_vc == VC_W'(v));
            pop_vec[v]  = load && (grant_vc == VC_W'(v));
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RESET: state_d = ST_INIT;
            ST_INIT:  if (!vc_if.init) state_d = ST_IDLE;
            ST_IDLE, ST_ACTIVE: begin
                if (overflow)                    state_d = ST_ERROR;
                else if (vc_if.init)             state_d = ST_INIT;
                else if (any_ne || out_valid_q)  state_d = ST_ACTIVE;
                else                             state_d = ST_IDLE;
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_RESET;
        endcase
    end

    always_comb begin
        thr_hi_d    = thr_hi_q;
        thr_lo_d    = thr_lo_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        error_id_d  = error_id_q;
        pause_d     = pause_q;

        if (state_q == ST_INIT && vc_if.umbral_lo_in < vc_if.umbral_hi_in &&
            vc_if.umbral_hi_in <= DEPTH_C) begin
            thr_hi_d = vc_if.umbral_hi_in;
            thr_lo_d = vc_if.umbral_lo_in;
        end

        if (any_hi)      pause_d = 1'b1;
        else if (all_lo) pause_d = 1'b0;

        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[grant_vc][rd_ptr_q[grant_vc]];
        end else if (vc_if.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (state_d == ST_ERROR) out_valid_d = 1'b0;

        if (overflow) error_id_d = error_id_q | (NUM_VC'(1) << push_vc);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RESET;
            thr_hi_q    <= CNT_W'(VC_DEPTH - 2);
            thr_lo_q    <= CNT_W'(2);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            pause_q     <= 1'b0;
            error_id_q  <= '0;
        end else begin
            state_q     <= state_d;
            thr_hi_q    <= thr_hi_d;
            thr_lo_q    <= thr_lo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            pause_q     <= pause_d;
            error_id_q  <= error_id_d;
        end
    end

    // Clearing counts discards buffered words; storage itself needs no reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr_q[v] <= '0;
                rd_ptr_q[v] <= '0;
                cnt_q[v]    <= '0;
            end
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push_vec[v]) wr_ptr_q[v] <= wr_ptr_q[v] + PTR_W'(1);
                if (pop_vec[v])  rd_ptr_q[v] <= rd_ptr_q[v] + PTR_W'(1);
                cnt_q[v] <= cnt_q[v] + CNT_W'(push_vec[v]) - CNT_W'(pop_vec[v]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[push_vc][wr_ptr_q[push_vc]] <= vc_if.in_data;
    end

    assign vc_if.out_valid  = out_valid_q;
    assign vc_if.out_data   = out_data_q;
    assign vc_if.in_pause   = pause_q;
    assign vc_if.idle_out   = (state_q == ST_IDLE);
    assign vc_if.active_out = (state_q == ST_ACTIVE);
    assign vc_if.error_out  = (state_q == ST_ERROR);
    assign vc_if.error_id   = error_id_q;
endmodule

// File: tb/tb_pcie_vc_router.sv
// Bench for pcie_vc_router: queue-level reference model compared every cycle, plus directed scenarios.
module tb_pcie_vc_router;
    localparam int DATA_W   = 6;
    localparam int NUM_VC   = 2;
    localparam int VC_DEPTH = 16;
    localparam int CNT_W    = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pcie_vc_router_if #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .CNT_W(CNT_W)) bus ();

    pcie_vc_router #(.DATA_W(DATA_W), .NUM_VC(NUM_VC), .VC_DEPTH(VC_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .vc_if (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] got[$];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: states 0=RESET 1=INIT 2=IDLE 3=ACTIVE 4=ERROR
    int               m_st = 0;
    logic [DATA_W-1:0] mq[NUM_VC][$];
    bit               m_ov = 0;
    logic [DATA_W-1:0] m_od = '0;
    bit               m_pause = 0;
    int               m_hi = VC_DEPTH - 2;
    int               m_lo = 2;
    bit [NUM_VC-1:0]  m_err = '0;
    int               m_rr = 0;

    always @(posedge clk or posedge reset) begin : model
        int vc, sel, nst, idx;
        bit run, anyne, anyhi, alllo, take, ovf;
        if (reset) begin
            m_st = 0;
            for (int v = 0; v < NUM_VC; v++) mq[v].delete();
            m_ov = 0; m_od = '0; m_pause = 0;
            m_hi = VC_DEPTH - 2; m_lo = 2; m_err = '0; m_rr = 0;
        end else begin
            run = (m_st == 2) || (m_st == 3);
            anyne = 0; anyhi = 0; alllo = 1;
            for (int v = 0; v < NUM_VC; v++) begin
                if (mq[v].size() > 0) anyne = 1;
                if (mq[v].size() >= m_hi) anyhi = 1;
                if (mq[v].size() > m_lo) alllo = 0;
            end
            sel = -1;
`ifdef VC_RR_ARB_EN
            for (int k = 0; k < NUM_VC; k++) begin
                idx = (m_rr + k) % NUM_VC;
                if (sel < 0 && mq[idx].size() > 0) sel = idx;
            end
`else
            for (int k = 0; k < NUM_VC; k++)
                if (sel < 0 && mq[k].size() > 0) sel = k;
`endif
            take = run && (!m_ov || bus.out_ready) && (sel >= 0);
            vc   = int'(bus.in_data) >> (DATA_W - $clog2(NUM_VC));
            ovf  = run && bus.in_valid && (mq[vc].size() == VC_DEPTH) && !(take && sel == vc);
            if (ovf) take = 0;

            case (m_st)
                0: nst = 1;
                1: nst = bus.init ? 1 : 2;
                2, 3: begin
                    if (ovf)                 nst = 4;
                    else if (bus.init)       nst = 1;
                    else if (anyne || m_ov)  nst = 3;
                    else                     nst = 2;
                end
                default: nst = 4;
            endcase

            if (m_st == 1 && bus.umbral_lo_in < bus.umbral_hi_in && bus.umbral_hi_in <= VC_DEPTH) begin
                m_hi = int'(bus.umbral_hi_in);
                m_lo = int'(bus.umbral_lo_in);
            end
            if (anyhi)      m_pause = 1;
            else if (alllo) m_pause = 0;

            if (take) begin
                m_od = mq[sel].pop_front();
                m_ov = 1;
                m_rr = (sel + 1) % NUM_VC;
            end else if (bus.out_ready) begin
                m_ov = 0;
            end
            if (run && bus.in_valid && !ovf) mq[vc].push_back(bus.in_data);
            if (ovf) m_err[vc] = 1'b1;
            m_st = nst;
            if (m_st == 4) m_ov = 0;
        end
    end

    bit cmp_en = 0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("out_valid", int'(bus.out_valid), int'(m_ov));
            if (m_ov) chk("out_data", int'(bus.out_data), int'(m_od));
            chk("in_pause", int'(bus.in_pause), int'(m_pause));
            chk("idle_out", int'(bus.idle_out), int'(m_st == 2));
            chk("active_out", int'(bus.active_out), int'(m_st == 3));
            chk("error_out", int'(bus.error_out), int'(m_st == 4));
            chk("error_id", int'(bus.error_id), int'(m_err));
            if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        cyc();
        bus.in_valid = 1'b0;
    endtask

    // Asynchronous reset, then RESET->INIT, one INIT cycle latching hi/lo, then IDLE.
    task automatic do_reset(input int hi, input int lo);
        reset = 1'b1;
        #1;
        chk("async reset out_valid", int'(bus.out_valid), 0);
        bus.init = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.umbral_hi_in = CNT_W'(hi);
        bus.umbral_lo_in = CNT_W'(lo);
        cyc(2);
        chk("reset out_data", int'(bus.out_data), 0);
        chk("reset idle_out", int'(bus.idle_out), 0);
        chk("reset error_id", int'(bus.error_id), 0);
        chk("reset in_pause", int'(bus.in_pause), 0);
        reset = 1'b0;
        bus.init = 1'b1;
        cyc(2);
        chk("init idle_out", int'(bus.idle_out), 0);
        bus.init = 1'b0;
        cyc();
        chk("idle after init", int'(bus.idle_out), 1);
    endtask

    initial begin : wdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1;
        bus.init = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus.umbral_hi_in = '0; bus.umbral_lo_in = '0;
        cmp_en = 1;

        // Single word latency and return to idle
        do_reset(14, 2);
        bus.out_ready = 1'b1;
        push(6'h05);
        chk("no bypass out_valid", int'(bus.out_valid), 0);
        cyc();
        chk("first word out_valid", int'(bus.out_valid), 1);
        chk("first word out_data", int'(bus.out_data), 'h05);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!bus.idle_out && n < 8);
        chk("return to idle", int'(bus.idle_out), 1);

        // Arbitration order: A0 parks in the output register, the rest queue
        do_reset(14, 2);
        got.delete();
        push(6'h01); push(6'h02); push(6'h21); push(6'h22);
        bus.out_ready = 1'b1;
        cyc(8);
        chk("arb count", got.size(), 4);
        if (got.size() == 4) begin
`ifdef VC_RR_ARB_EN
            chk("arb word1", int'(got[1]), 'h21);
            chk("arb word2", int'(got[2]), 'h02);
`else
            chk("arb word1", int'(got[1]), 'h02);
            chk("arb word2", int'(got[2]), 'h21);
`endif
            chk("arb word0", int'(got[0]), 'h01);
            chk("arb word3", int'(got[3]), 'h22);
        end

        // Hysteresis with hi=8, lo=3; a VC1 word occupies the output register first
        do_reset(8, 3);
        push(6'h3F);
        for (int i = 0; i < 8; i++) push(6'(i));
        chk("pause before", int'(bus.in_pause), 0);
        cyc();
        chk("pause set at 8", int'(bus.in_pause), 1);
        bus.out_ready = 1'b1;
        cyc(4);
        bus.out_ready = 1'b0;
        cyc();
        chk("pause held at 4", int'(bus.in_pause), 1);
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        cyc();
        chk("pause clear at 3", int'(bus.in_pause), 0);

        // Overflow of VC1 on the 17th push, then sticky ERROR
        do_reset(14, 2);
        push(6'h0A);
        for (int i = 0; i < 16; i++) push(6'h20 | 6'(i));
        chk("no error at 16", int'(bus.error_out), 0);
        push(6'h30);
        chk("overflow error_id", int'(bus.error_id), 'b10);
        chk("overflow error_out", int'(bus.error_out), 1);
        chk("overflow out_valid", int'(bus.out_valid), 0);
        bus.in_valid = 1'b1; bus.in_data = 6'h01; bus.init = 1'b1;
        cyc(3);
        bus.in_valid = 1'b0; bus.init = 1'b0;
        cyc();
        chk("error sticky", int'(bus.error_out), 1);
        chk("error_id sticky", int'(bus.error_id), 'b10);
        chk("error not idle", int'(bus.idle_out), 0);

        // Rejected threshold load keeps 14/2; stall then drain without loss
        do_reset(5, 9);
        got.delete();
        push(6'h2B);
        for (int i = 0; i < 13; i++) push(6'h10 + 6'(i));
        cyc();
        chk("pause clear at 13", int'(bus.in_pause), 0);
        push(6'h1D);
        cyc();
        chk("pause set at 14", int'(bus.in_pause), 1);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall out_valid", int'(bus.out_valid), 1);
            chk("stall out_data", int'(bus.out_data), 'h2B);
        end
        bus.out_ready = 1'b1;
        cyc(20);
        chk("drain count", got.size(), 15);
        if (got.size() == 15) begin
            chk("drain head", int'(got[0]), 'h2B);
            for (int i = 0; i < 14; i++) chk("drain word", int'(got[i + 1]), 'h10 + i);
        end

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
